slc3_mem_responder: RTL
=======================

# slc3_mem_responder

On-chip memory responder for the SLC-3 core: the target end of the core's ADDR/OE/WE/Data_to_SRAM/Data_from_SRAM memory interface. It holds a DEPTH-word RAM with a configurable read latency. After every reset it preloads the RAM from an external synchronous program ROM, then raises `ready` so the top level can release the core.

## Interface
- DEPTH, 1024: RAM words; a power of 2; AW = clog2(DEPTH).
- READ_LAT, 2: read latency in clock edges, legal range 1..3.
- INIT_WORDS, 256: words copied from ROM after reset, 0..DEPTH.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ADDR  in  16  word address from the core (MAR).
- OE  in  1  active-high read strobe.
- WE  in  1  active-high write strobe.
- Data_to_SRAM  in  16  write data from the core.
- Data_from_SRAM  out  16  read data to the core.
- rom_addr  out  AW  program ROM address.
- rom_en  out  1  ROM read enable.
- rom_data  in  16  ROM data, valid one edge after `rom_en`/`rom_addr` are sampled.
- ready  out  1  high once the preload has finished.
- addr_err  out  1  one-cycle pulse on an out-of-range access.

## Operation
- States: INIT and RUN. Reset forces INIT with a preload counter `cnt` of 0.
- INIT, address phase:
  - `rom_en` = 1 while `cnt` < INIT_WORDS.
  - `rom_addr` = `cnt`.
  - `cnt` increments each edge.
- INIT, data phase: on the edge after address k is sampled, mem[k] <= `rom_data`. The write pipeline is one stage deep.
- INIT exit: after the write of word INIT_WORDS-1, the state goes to RUN and `ready` = 1. With INIT_WORDS = 0 the state goes to RUN on the first edge after reset release.
- In INIT, core strobes are ignored: no writes, no reads, and `addr_err` is not raised.
- In RANGE means ADDR[15:AW] == 0. Any other address is out of range.
- RUN, write: on an edge with WE=1 and an in-range address, mem[ADDR[AW-1:0]] <= `Data_to_SRAM`.
- RUN, read: on an edge with OE=1, WE=0 and an in-range address, mem[ADDR] is sampled into stage 1 of a READ_LAT-deep valid/data pipeline.
  - Stages advance every edge.
  - `Data_from_SRAM` updates only when a valid entry leaves the last stage. Otherwise it holds its last value.
- OE and WE high together: the write wins and no read is issued.
- Out-of-range read: a valid entry with data 0x0000 enters the pipeline.
- Out-of-range write: dropped.
- Out-of-range access of either kind pulses `addr_err` high for the cycle after the edge.
- Reads and writes are independent each cycle, and back-to-back accesses are allowed.
- A read issued the edge after a write to the same address returns the new data.
- Reset mid-operation:
  - The read pipeline is flushed.
  - The preload restarts at word 0.
  - RAM words at INIT_WORDS and above keep their contents; RAM is never bulk-cleared.
- Reset values: `Data_from_SRAM` = 0, `ready` = 0, `rom_en` = 0, `rom_addr` = 0, `addr_err` = 0, all pipeline valid bits = 0.

## Timing
- Preload length: `ready` rises on edge INIT_WORDS+1 after reset deassertion, counting the first edge as 1.
- Read latency: OE sampled at edge n gives the data on `Data_from_SRAM` after edge n+READ_LAT-1.
  - READ_LAT=1 means the data is visible in the cycle after the sampling edge.
  - The core's three-state OE hold covers READ_LAT up to 3.
- Writes take effect at the sampling edge, with no wait states.
- All outputs are registered. There is no combinational path from ADDR/OE/WE to `Data_from_SRAM`.
- `addr_err` is registered and lasts exactly one cycle per offending access.

## Test plan
- Preload: INIT_WORDS=4, ROM returns 0x1000+addr.
  - `rom_addr` steps 0..3.
  - `ready` rises at edge 5.
  - Reads at 0..3 return 0x1000..0x1003.
  - Strobes issued before `ready` have no effect.
- Latency sweep, READ_LAT=1,2,3: write 0xBEEF to 0x0010, then read 0x0010.
  - Data appears exactly READ_LAT-1 edges after the OE edge.
  - The output holds 0xBEEF afterwards with OE low.
- Write-then-read: write 0x1234 to 0x0020, read 0x0020 on the next edge; the read returns 0x1234. With OE=WE=1 on 0x0021 carrying 0x5555, a later read returns 0x5555 and the output is unchanged at the dual-strobe edge.
- Out of range (DEPTH=1024): write 0xFFFF to 0x0400, then read 0x0400.
  - Each access produces one `addr_err` pulse.
  - The read returns 0x0000.
  - mem[0x0000] is unchanged.
- Back-to-back reads of 0x0001, 0x0002, 0x0003 with READ_LAT=2 produce consecutive output values on three consecutive cycles.
- Reset mid-operation: assert Reset with a read in flight.
  - All outputs go to their reset values immediately.
  - The preload repeats.
  - A word written at 0x0300 before the reset still reads back after `ready`.

Source files
------------

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory target: preloads DEPTH-word RAM from a sync ROM after reset, then serves core reads/writes.
// Reads return READ_LAT-1 edges after the OE edge; writes land at the sampling edge; no backpressure.
module slc3_mem_responder #(
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 2,
  parameter int INIT_WORDS = 256
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [15:0]              ADDR,
  input  logic                     OE,
  input  logic                     WE,
  input  logic [15:0]              Data_to_SRAM,
  output logic [15:0]              Data_from_SRAM,
  output logic [$clog2(DEPTH)-1:0] rom_addr,
  output logic                     rom_en,
  input  logic [15:0]              rom_data,
  output logic                     ready,
  output logic                     addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NW = (AW+1)'(INIT_WORDS);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt;
  logic            wr_pend;
  logic [AW-1:0]   wr_idx;
  logic [15:0]     mem [DEPTH];

  logic            run;
  logic            preload_req;
  logic            in_range;
  logic            cpu_wr;
  logic            rd_issue;
  logic [15:0]     rd_dat;
  logic            last_vld;
  logic [15:0]     last_dat;

  assign run         = (state_q == S_RUN);
  assign preload_req = (state_q == S_INIT) && (cnt < NW);
  assign in_range    = (ADDR[15:AW] == '0);
  assign cpu_wr      = run && WE && in_range;
  assign rd_issue    = run && OE && !WE;
  assign rd_dat      = in_range ? mem[ADDR[AW-1:0]] : 16'h0000;

  // ROM strobes decode straight from the counter so word 0 is fetched on the first edge after release;
  // Reset gates rom_en so the ROM sees no request while reset is held.
  assign rom_en   = preload_req && !Reset;
  assign rom_addr = cnt[AW-1:0];
  assign ready    = run;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (cnt == NW) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      wr_pend <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (preload_req) cnt <= cnt + 1'b1;
      wr_pend <= preload_req;
      wr_idx  <= cnt[AW-1:0];
    end
  end

  // Preload writes only happen in INIT and core writes only in RUN, so one write port suffices.
  always_ff @(posedge Clk) begin
    if (wr_pend)     mem[wr_idx]         <= rom_data;
    else if (cpu_wr) mem[ADDR[AW-1:0]]   <= Data_to_SRAM;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) addr_err <= 1'b0;
    else       addr_err <= run && (OE || WE) && !in_range;
  end

  generate
    if (READ_LAT <= 1) begin : g_lat1
      assign last_vld = rd_issue;
      assign last_dat = rd_dat;
    end else begin : g_latn
      logic [READ_LAT-2:0] pv;
      logic [15:0]         pd [READ_LAT-1];

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          pv <= '0;
          for (int i = 0; i < READ_LAT-1; i++) pd[i] <= 16'h0000;
        end else begin
          pv[0] <= rd_issue;
          pd[0] <= rd_dat;
          for (int i = 1; i < READ_LAT-1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign last_vld = pv[READ_LAT-2];
      assign last_dat = pd[READ_LAT-2];
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         Data_from_SRAM <= 16'h0000;
    else if (last_vld) Data_from_SRAM <= last_dat;
  end

endmodule
